// File: rtl/fc_pkg.sv
// Shared types and defaults for the FC run controller.
package fc_pkg;

   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StDrain,
      StDone
   } fc_state_e;

endpackage

// File: rtl/fc_idx_gen.sv
// Nested beat/neuron index counter; holds the final indices after the last beat.
module fc_idx_gen
   import fc_pkg::*;
#(
   parameter int unsigned CntW = CNT_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_clear,
   input  logic            i_advance,
   input  logic [CntW-1:0] i_num_in,
   input  logic [CntW-1:0] i_num_out,
   output logic [CntW-1:0] o_in_idx,
   output logic [CntW-1:0] o_out_idx,
   output logic            o_last_beat,
   output logic            o_last_neuron
);

   logic [CntW-1:0] r_in_idx;
   logic [CntW-1:0] r_out_idx;

   assign o_last_beat   = (r_in_idx == (i_num_in - CntW'(1)));
   assign o_last_neuron = (r_out_idx == (i_num_out - CntW'(1)));
   assign o_in_idx      = r_in_idx;
   assign o_out_idx     = r_out_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_in_idx  <= '0;
         r_out_idx <= '0;
      end else if (i_clear) begin
         r_in_idx  <= '0;
         r_out_idx <= '0;
      end else if (i_advance) begin
         if (!o_last_beat) begin
            r_in_idx <= r_in_idx + CntW'(1);
         end else if (!o_last_neuron) begin
            r_in_idx  <= '0;
            r_out_idx <= r_out_idx + CntW'(1);
         end
      end
   end

endmodule

// File: rtl/fc_run_ctrl.sv
// FC layer run controller: issues MAC beats for one command and tracks returned results.
module fc_run_ctrl
   import fc_pkg::*;
#(
   parameter int unsigned CNT_W = fc_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [CNT_W-1:0] cmd_num_out,
   input  logic [CNT_W-1:0] cmd_num_in,
   output logic             start,
   output logic             done,
   output logic             mac_valid,
   input  logic             mac_ready,
   output logic             mac_last,
   output logic [CNT_W-1:0] out_idx,
   output logic [CNT_W-1:0] in_idx,
   input  logic             acc_valid,
   output logic             err
);

   fc_state_e        r_state, w_state_d;
   logic [CNT_W-1:0] r_num_out, r_num_in;
   logic [CNT_W-1:0] r_res_cnt, r_last_cnt;
   logic             r_err;

   logic             w_cmd_take, w_zero_cmd, w_running;
   logic             w_beat, w_last_beat, w_last_neuron, w_last_acc, w_final_acc;
   logic [CNT_W:0]   w_lasts_incl;
   logic             w_acc_ok;
   logic [CNT_W-1:0] w_res_next;
   logic             w_res_full;

   fc_idx_gen #(
      .CntW (CNT_W)
   ) u_idx_gen (
      .clk           (clk),
      .rst           (rst),
      .i_clear       (w_cmd_take),
      .i_advance     (w_beat),
      .i_num_in      (r_num_in),
      .i_num_out     (r_num_out),
      .o_in_idx      (in_idx),
      .o_out_idx     (out_idx),
      .o_last_beat   (w_last_beat),
      .o_last_neuron (w_last_neuron)
   );

   assign cmd_ready = (r_state == StIdle) || (r_state == StDone);
   assign start     = (r_state != StIdle);
   assign done      = (r_state == StDone);
   assign mac_valid = (r_state == StIssue);
   assign mac_last  = (r_state == StIssue) && w_last_beat;
   assign err       = r_err;

   assign w_cmd_take  = cmd_valid && cmd_ready;
   assign w_zero_cmd  = (cmd_num_out == '0) || (cmd_num_in == '0);
   assign w_running   = (r_state == StIssue) || (r_state == StDrain);
   assign w_beat      = mac_valid && mac_ready;
   assign w_last_acc  = w_beat && w_last_beat;
   assign w_final_acc = w_last_acc && w_last_neuron;

   // A result is legal only against a neuron whose last beat was accepted, this cycle included.
   assign w_lasts_incl = {1'b0, r_last_cnt} + (CNT_W + 1)'(w_last_acc);
   assign w_acc_ok     = w_running && acc_valid && ({1'b0, r_res_cnt} < w_lasts_incl);
   assign w_res_next   = r_res_cnt + CNT_W'(w_acc_ok);
   assign w_res_full   = (w_res_next == r_num_out);

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle, StDone: begin
            if (cmd_valid) w_state_d = w_zero_cmd ? StDone : StIssue;
         end
         StIssue: begin
            if (w_final_acc) w_state_d = w_res_full ? StDone : StDrain;
         end
         StDrain: begin
            if (w_res_full) w_state_d = StDone;
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= StIdle;
         r_num_out  <= '0;
         r_num_in   <= '0;
         r_res_cnt  <= '0;
         r_last_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_state_d;
         if (acc_valid && !w_acc_ok) r_err <= 1'b1;
         if (w_cmd_take) begin
            r_num_out  <= cmd_num_out;
            r_num_in   <= cmd_num_in;
            r_res_cnt  <= '0;
            r_last_cnt <= '0;
         end else begin
            r_res_cnt <= w_res_next;
            if (w_last_acc) r_last_cnt <= r_last_cnt + CNT_W'(1);
         end
      end
   end

endmodule
